multitone_dds_generator: RTL and testbench
==========================================

Name: multitone_dds_generator

Overview:
Synthesizable N-tone direct-digital-synthesis stimulus source for characterising the FIR filter under two-tone/multi-tone (IMD) conditions.
- Per tone: independent phase accumulator, frequency control word, amplitude and enable.
- Tones are summed with saturation into one signed sample stream paced by an external sample tick.
- Runs bursts of a programmed sample count, or runs continuously; output uses a valid/ready handshake to feed the FIR input.

Parameters:
- DATA_WIDTH, 16: output sample and sine LUT width, signed.
- N_TONES, 2: number of tones, >=1.
- PHASE_WIDTH, 32: phase accumulator width.
- LUT_ADDR_WIDTH, 8: quarter-wave resolution; phase index uses top LUT_ADDR_WIDTH+2 bits.
- AMP_WIDTH, 16: unsigned amplitude width; full scale is 2^AMP_WIDTH-1.
- COUNT_WIDTH, 32: sample counter width.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-low reset.
- cfg_we, in, 1: config write strobe.
- cfg_tone, in, $clog2(N_TONES) (min 1): tone index; writes to index >= N_TONES are ignored.
- cfg_fcw, in, PHASE_WIDTH: frequency control word.
- cfg_amp, in, AMP_WIDTH: amplitude.
- cfg_en, in, 1: tone enable.
- start, in, 1: begin run (pulse).
- stop, in, 1: abort run (pulse).
- num_samples, in, COUNT_WIDTH: burst length; 0 = continuous.
- sample_tick, in, 1: one-cycle sample-rate strobe.
- out_data, out, DATA_WIDTH: signed summed sample.
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: sink accepts.
- busy, out, 1: state != IDLE.
- done, out, 1: one-cycle pulse at end of run.
- overrun, out, 1: sticky; a tick was dropped.
- sat_count, out, COUNT_WIDTH: number of saturated samples; saturates at all-ones.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all tone fcw/amp/en = 0; phases 0; out_data 0; out_valid 0; done 0; overrun 0; sat_count 0. Reset mid-run aborts immediately and discards in-flight samples.
- Config: cfg_we registers fcw/amp/en for cfg_tone in any state. New values apply from the next accepted tick.
- FSM IDLE:
  - start -> RUN: phases cleared to 0, counter loaded with num_samples, overrun and sat_count cleared.
  - stop in IDLE is ignored; start and stop in the same cycle in IDLE -> start wins.
- FSM RUN:
  - Tick accepted iff sample_tick=1, pipeline stages 1-2 empty, and (!out_valid || out_ready).
  - A tick not meeting this condition sets overrun, is dropped, and does not decrement the counter.
  - Per accepted tick, per tone: sample uses the current phase, then phase += fcw mod 2^PHASE_WIDTH. Phase of a disabled tone holds.
  - Counter decrements per accepted tick. Reaching 0 from a nonzero load -> DRAIN.
  - stop -> DRAIN. start while busy is ignored.
- FSM DRAIN: no ticks accepted. When the pipeline is empty and out_valid=0 -> done=1 for one cycle, state IDLE.
- Sine:
  - s = round(A * sin(2*pi*p / 2^(LUT_ADDR_WIDTH+2))), with A = 2^(DATA_WIDTH-1)-1 and p = top LUT_ADDR_WIDTH+2 phase bits.
  - Quarter-wave table of 2^LUT_ADDR_WIDTH+1 entries plus quadrant mirroring.
  - p=0 -> 0; p=2^L -> +A; p=3*2^L -> -A.
- Scaling: product = s * amp (signed x unsigned), arithmetic right shift by AMP_WIDTH (floor). A disabled tone contributes 0.
- Sum:
  - Accumulate in DATA_WIDTH+$clog2(N_TONES)+1 bits.
  - Clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Each clamped sample increments sat_count.
- Pipeline and latency:
  - Stage 1: LUT. Stage 2: multiply. Stage 3: sum/saturate into the output register.
  - out_valid rises exactly 3 cycles after the accepting tick cycle.
- Output: out_data/out_valid hold stable until out_ready=1 while out_valid=1; out_valid clears the cycle after the transfer unless a new sample lands.

Test Plan:
1. Reset: assert rst=0 for 2 cycles while in RUN with out_valid=1 -> out_valid=0, busy=0, done=0. Rerun with no cfg writes -> all samples 0.
2. Single tone: tone0 fcw=2^30, amp=0xFFFF, en=1; num_samples=4; ticks every 10 cycles; out_ready=1.
   - Outputs 0, 32766, 0, -32767, each 3 cycles after its tick.
   - Then done pulses once and busy=0; sat_count=0.
3. Two-tone saturation: both tones fcw=2^30, amp=0xFFFF, en=1; num_samples=4 -> outputs 0, 32767, 0, -32768; sat_count=2.
4. Backpressure: same as 2 with out_ready=0 -> first sample held stable, later ticks dropped, overrun=1. Release ready -> next accepted tick yields 32766 (counter was not decremented by dropped ticks).
5. Continuous/stop: num_samples=0, single tone running. Pulse stop 1 cycle after a tick -> that in-flight sample is delivered, then done. Restart -> first sample 0 (phase cleared).
6. Mid-run reconfig: tone0 fcw=2^30. After sample 2, write fcw=2^31 -> next samples 0 (p=2*2^L), then 0, 0 (phase steps by half cycle from 2^31). The write does not disturb the sample in flight.

Source files
------------

// File: rtl/multitone_dds_generator.sv
// multitone_dds_generator: N-tone DDS source; ports: clk/rst (sync, active-low), cfg_we/cfg_tone/cfg_fcw/cfg_amp/cfg_en tone config, start/stop/num_samples run control, sample_tick pacing, out_data/out_valid/out_ready stream, busy/done/overrun/sat_count status
module multitone_dds_generator #(
  parameter int DATA_WIDTH = 16,
  parameter int N_TONES = 2,
  parameter int PHASE_WIDTH = 32,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int AMP_WIDTH = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_we,
  input  logic [(N_TONES > 1 ? $clog2(N_TONES) : 1)-1:0] cfg_tone,
  input  logic [PHASE_WIDTH-1:0] cfg_fcw,
  input  logic [AMP_WIDTH-1:0] cfg_amp,
  input  logic cfg_en,
  input  logic start,
  input  logic stop,
  input  logic [COUNT_WIDTH-1:0] num_samples,
  input  logic sample_tick,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic busy,
  output logic done,
  output logic overrun,
  output logic [COUNT_WIDTH-1:0] sat_count
);
  localparam int L = LUT_ADDR_WIDTH;
  localparam int QN = 1 << L;
  localparam int SW = DATA_WIDTH + $clog2(N_TONES) + 1;
  localparam int MW = DATA_WIDTH + AMP_WIDTH;
  localparam real A = real'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] SMAX = SW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] SMIN = ~SMAX;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state;
  logic [PHASE_WIDTH-1:0] r_fcw [N_TONES];
  logic [PHASE_WIDTH-1:0] r_phase [N_TONES];
  logic [AMP_WIDTH-1:0] r_amp [N_TONES];
  logic [AMP_WIDTH-1:0] r_s1_amp [N_TONES];
  logic [N_TONES-1:0] r_en;
  logic signed [DATA_WIDTH-1:0] r_s1_smp [N_TONES];
  logic signed [DATA_WIDTH-1:0] r_s2_prod [N_TONES];
  logic signed [DATA_WIDTH-1:0] r_out_data;
  logic r_s1_valid, r_s2_valid, r_out_valid, r_done, r_overrun, r_cont;
  logic [COUNT_WIDTH-1:0] r_cnt, r_sat;
  logic signed [DATA_WIDTH-1:0] w_lut [0:QN];
  logic [L:0] w_ix [N_TONES];
  logic signed [DATA_WIDTH-1:0] w_s [N_TONES];
  logic signed [MW-1:0] w_prod [N_TONES];
  logic signed [SW-1:0] w_sum;
  logic w_accept, w_hi, w_lo;
  for (genvar k = 0; k <= QN; k++) begin : g_lut
    assign w_lut[k] = DATA_WIDTH'($rtoi(A * $sin(3.141592653589793 * real'(k) / real'(2 * QN)) + 0.5));
  end
  always_comb begin
    for (int t = 0; t < N_TONES; t++) begin
      w_ix[t] = r_phase[t][PHASE_WIDTH-2] ? (L+1)'(QN) - {1'b0, r_phase[t][PHASE_WIDTH-3 -: L]} : {1'b0, r_phase[t][PHASE_WIDTH-3 -: L]};
      w_s[t] = r_phase[t][PHASE_WIDTH-1] ? -w_lut[w_ix[t]] : w_lut[w_ix[t]];
      w_prod[t] = MW'(r_s1_smp[t]) * MW'($signed({1'b0, r_s1_amp[t]}));
    end
  end
  always_comb begin
    w_sum = '0;
    for (int t = 0; t < N_TONES; t++) w_sum = w_sum + SW'(r_s2_prod[t]);
  end
  assign w_hi = w_sum > SMAX;
  assign w_lo = w_sum < SMIN;
  assign w_accept = (r_state == RUN) && sample_tick && !r_s1_valid && !r_s2_valid && (!r_out_valid || out_ready);
  assign out_data = r_out_data;
  assign out_valid = r_out_valid;
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign overrun = r_overrun;
  assign sat_count = r_sat;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_done <= 1'b0;
      r_overrun <= 1'b0;
      r_sat <= '0;
      r_cnt <= '0;
      r_cont <= 1'b0;
      r_en <= '0;
      for (int t = 0; t < N_TONES; t++) begin
        r_fcw[t] <= '0;
        r_amp[t] <= '0;
        r_phase[t] <= '0;
        r_s1_smp[t] <= '0;
        r_s1_amp[t] <= '0;
        r_s2_prod[t] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (cfg_we && int'(cfg_tone) < N_TONES) begin
        r_fcw[cfg_tone] <= cfg_fcw;
        r_amp[cfg_tone] <= cfg_amp;
        r_en[cfg_tone] <= cfg_en;
      end
      r_s1_valid <= w_accept;
      if (w_accept) begin
        for (int t = 0; t < N_TONES; t++) begin
          r_s1_smp[t] <= w_s[t];
          r_s1_amp[t] <= r_en[t] ? r_amp[t] : '0;
          if (r_en[t]) r_phase[t] <= r_phase[t] + r_fcw[t];
        end
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int t = 0; t < N_TONES; t++) r_s2_prod[t] <= DATA_WIDTH'(w_prod[t] >>> AMP_WIDTH);
      end
      if (r_s2_valid) begin
        r_out_valid <= 1'b1;
        r_out_data <= w_hi ? SMAX[DATA_WIDTH-1:0] : w_lo ? SMIN[DATA_WIDTH-1:0] : w_sum[DATA_WIDTH-1:0];
        if ((w_hi || w_lo) && !(&r_sat)) r_sat <= r_sat + COUNT_WIDTH'(1);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_cnt <= num_samples;
            r_cont <= num_samples == '0;
            r_overrun <= 1'b0;
            r_sat <= '0;
            for (int t = 0; t < N_TONES; t++) r_phase[t] <= '0;
          end
        end
        RUN: begin
          if (sample_tick && !w_accept) r_overrun <= 1'b1;
          if (w_accept) r_cnt <= r_cnt - COUNT_WIDTH'(1);
          if (stop || (w_accept && !r_cont && r_cnt == COUNT_WIDTH'(1))) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!r_s1_valid && !r_s2_valid && !r_out_valid) begin
            r_state <= IDLE;
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multitone_dds_generator.sv
// tb_multitone_dds_generator: randomized and directed checks of multitone_dds_generator against a real-valued sine/queue reference model
module tb_multitone_dds_generator;
  logic clk = 0, rst = 0, cfg_we = 0, cfg_tone = 0, cfg_en = 0;
  logic start = 0, stop = 0, sample_tick = 0, out_ready = 0;
  logic [31:0] cfg_fcw = 0, num_samples = 0;
  logic [15:0] cfg_amp = 0;
  logic [15:0] out_data;
  logic out_valid, busy, done, overrun;
  logic [31:0] sat_count;
  int n_pass = 0, n_total = 0, done_cnt = 0, cyc_n = 0;
  int got[$];
  int exp_q[$];
  bit checking = 0;
  int m_state, m_pend_val, m_pend_t, m_data, m_left, a_v;
  bit [31:0] m_phase [2];
  bit [31:0] m_fcw [2];
  int m_amp [2];
  bit m_en [2];
  bit m_pend, m_valid, m_done, m_ov, m_cont, a_acc, a_drained;
  longint m_sat;
  multitone_dds_generator dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_tone(cfg_tone), .cfg_fcw(cfg_fcw),
    .cfg_amp(cfg_amp), .cfg_en(cfg_en), .start(start), .stop(stop),
    .num_samples(num_samples), .sample_tick(sample_tick), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .overrun(overrun), .sat_count(sat_count)
  );
  always #5 clk = ~clk;
  function automatic int contrib(bit [31:0] ph, int amp);
    int p, s;
    real x;
    longint pr;
    p = int'(ph[31:22]);
    x = 32767.0 * $sin(2.0 * 3.141592653589793 * p / 1024.0);
    s = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    pr = longint'(s) * longint'(amp);
    return int'(pr >>> 16);
  endfunction
  task automatic chk(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask
  always @(posedge clk) begin
    cyc_n++;
    if (!rst) begin
      m_state = 0; m_pend = 0; m_valid = 0; m_data = 0; m_done = 0; m_ov = 0; m_sat = 0;
      for (int t = 0; t < 2; t++) begin
        m_phase[t] = 0; m_fcw[t] = 0; m_amp[t] = 0; m_en[t] = 0;
      end
    end else begin
      a_acc = m_state == 1 && sample_tick && !m_pend && (!m_valid || out_ready);
      a_drained = !m_pend && !m_valid;
      m_done = 0;
      if (m_pend && m_pend_t == cyc_n) begin
        m_valid = 1;
        m_data = (m_pend_val > 32767) ? 32767 : (m_pend_val < -32768) ? -32768 : m_pend_val;
        if (m_pend_val > 32767 || m_pend_val < -32768) m_sat++;
        m_pend = 0;
      end else if (out_ready) m_valid = 0;
      if (a_acc) begin
        a_v = 0;
        for (int t = 0; t < 2; t++) if (m_en[t]) begin
          a_v += contrib(m_phase[t], m_amp[t]);
          m_phase[t] += m_fcw[t];
        end
        m_pend = 1; m_pend_val = a_v; m_pend_t = cyc_n + 2;
      end
      if (cfg_we) begin
        m_fcw[cfg_tone] = cfg_fcw; m_amp[cfg_tone] = int'(cfg_amp); m_en[cfg_tone] = cfg_en;
      end
      if (m_state == 0) begin
        if (start) begin
          m_state = 1; m_phase[0] = 0; m_phase[1] = 0;
          m_left = int'(num_samples); m_cont = num_samples == 0; m_ov = 0; m_sat = 0;
        end
      end else if (m_state == 1) begin
        if (sample_tick && !a_acc) m_ov = 1;
        if (a_acc) m_left--;
        if (stop || (a_acc && !m_cont && m_left == 0)) m_state = 2;
      end else if (a_drained) begin
        m_state = 0; m_done = 1;
      end
    end
  end
  always @(negedge clk) if (checking) begin
    chk("out_valid", out_valid, m_valid);
    if (m_valid) chk("out_data", int'($signed(out_data)), m_data);
    chk("busy", busy, m_state != 0);
    chk("done", done, m_done);
    chk("overrun", overrun, m_ov);
    chk("sat_count", sat_count, m_sat);
    if (out_valid && out_ready) got.push_back(int'($signed(out_data)));
    if (done) done_cnt++;
  end
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic cfg(int t, logic [31:0] f, logic [15:0] a, logic e);
    cfg_we = 1; cfg_tone = t[0]; cfg_fcw = f; cfg_amp = a; cfg_en = e;
    cyc(1);
    cfg_we = 0;
  endtask
  task automatic go(int n);
    got.delete(); done_cnt = 0; num_samples = n; start = 1;
    cyc(1);
    start = 0;
  endtask
  task automatic ticks(int n, int gap);
    repeat (n) begin sample_tick = 1; cyc(1); sample_tick = 0; cyc(gap - 1); end
  endtask
  task automatic wait_idle();
    int i = 0;
    while (busy && i < 500) begin cyc(1); i++; end
    chk("idle_timeout", busy, 0);
    cyc(2);
  endtask
  task automatic chk_got(string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk($sformatf("%s_%0d", name, i), got[i], exp_q[i]);
  endtask
  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
  initial begin
    cyc(3);
    checking = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", sat_count, 0);
    rst = 1;
    cyc(1);
    cfg(0, 32'h4000_0000, 16'hFFFF, 1);
    out_ready = 0;
    go(0);
    ticks(1, 6);
    chk("t1_held_valid", out_valid, 1);
    rst = 0;
    cyc(2);
    rst = 1;
    chk("t1_valid", out_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    out_ready = 1;
    go(3);
    ticks(3, 10);
    wait_idle();
    exp_q = '{0, 0, 0};
    chk_got("t1");
    cfg(0, 32'h4000_0000, 16'hFFFF, 1);
    go(4);
    ticks(4, 10);
    wait_idle();
    exp_q = '{0, 32766, 0, -32767};
    chk_got("t2");
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_sat", sat_count, 0);
    cfg(1, 32'h4000_0000, 16'hFFFF, 1);
    go(4);
    ticks(4, 10);
    wait_idle();
    exp_q = '{0, 32767, 0, -32768};
    chk_got("t3");
    chk("t3_sat", sat_count, 2);
    cfg(1, 0, 0, 0);
    out_ready = 0;
    go(4);
    ticks(4, 10);
    chk("t4_overrun", overrun, 1);
    chk("t4_valid", out_valid, 1);
    chk("t4_data", out_data, 0);
    chk("t4_none_taken", got.size(), 0);
    out_ready = 1;
    cyc(1);
    ticks(3, 10);
    wait_idle();
    exp_q = '{0, 32766, 0, -32767};
    chk_got("t4");
    go(0);
    ticks(3, 10);
    sample_tick = 1; cyc(1); sample_tick = 0;
    stop = 1; cyc(1); stop = 0;
    wait_idle();
    exp_q = '{0, 32766, 0, -32767};
    chk_got("t5");
    chk("t5_done_cnt", done_cnt, 1);
    go(1);
    ticks(1, 10);
    wait_idle();
    exp_q = '{0};
    chk_got("t5_restart");
    go(5);
    ticks(1, 10);
    sample_tick = 1; cyc(1); sample_tick = 0;
    cfg(0, 32'h8000_0000, 16'hFFFF, 1);
    cyc(8);
    ticks(3, 10);
    wait_idle();
    exp_q = '{0, 32766, 0, 0, 0};
    chk_got("t6");
    for (int i = 0; i < 4000; i++) begin
      sample_tick = ($urandom % 3) == 0;
      out_ready = ($urandom % 4) != 0;
      cfg_we = ($urandom % 16) == 0;
      cfg_tone = 1'($urandom % 2);
      cfg_fcw = $urandom;
      cfg_amp = 16'($urandom);
      cfg_en = ($urandom % 4) != 0;
      start = ($urandom % 25) == 0;
      stop = ($urandom % 90) == 0;
      num_samples = $urandom % 12;
      rst = ($urandom % 700) != 0;
      cyc(1);
    end
    {sample_tick, cfg_we, start} = 3'b000;
    rst = 1; out_ready = 1; stop = 1;
    cyc(1);
    stop = 0;
    wait_idle();
    checking = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
